// File: rtl/panda_seq_table_ctrl.sv
// Table-load controller: waits for the sequencer to go idle, then streams a table into it.
// Optional WAIT_INACTIVE watchdog enabled by defining SEQ_TBL_TIMEOUT_EN.
module panda_seq_table_ctrl #(
  parameter int unsigned FRAME_WORDS = 4,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter int unsigned TIMEOUT     = 125000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        load_req_i,
  input  logic [15:0] load_len_i,
  input  logic        abort_i,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic        seq_active_i,
  output logic        table_start_o,
  output logic [31:0] table_data_o,
  output logic        table_wstb_o,
  output logic [15:0] table_length_o,
  output logic        table_length_wstb_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  status_o
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BAD_LEN = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ABORTED = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INACTIVE,
    S_START,
    S_DATA,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [LEN_W-1:0]   r_word_cnt, w_word_cnt_nxt;
  logic [LEN_W-1:0]   r_table_length, w_table_length_nxt;
  logic [DATA_W-1:0]  r_table_data, w_table_data_nxt;
  logic [1:0]         r_status, w_status_nxt;
  logic               r_ready, w_ready_nxt;
  logic               r_table_start, w_table_start_nxt;
  logic               r_table_wstb, w_table_wstb_nxt;
  logic               r_length_wstb, w_length_wstb_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               w_accept;
  logic               w_len_bad;
  logic               w_timeout;

  assign w_accept  = (r_state == S_DATA) && r_ready && data_valid_i;
  assign w_len_bad = (load_len_i == '0) ||
                     (32'(load_len_i) > MAX_WORDS) ||
                     ((32'(load_len_i) % FRAME_WORDS) != 32'd0);

`ifdef SEQ_TBL_TIMEOUT_EN
  localparam int unsigned TMO_W = 32;
  logic [TMO_W-1:0] r_wait_cnt;

  // Cycles spent in WAIT_INACTIVE; restarts on every entry.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT_INACTIVE) begin
      r_wait_cnt <= r_wait_cnt + TMO_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT_INACTIVE) && (r_wait_cnt >= TIMEOUT);
`else
  // Without the watchdog WAIT_INACTIVE never gives up on its own.
  assign w_timeout = 1'b0 && (TIMEOUT != 32'd0);
`endif

  always_comb begin
    w_state_nxt        = r_state;
    w_len_nxt          = r_len;
    w_word_cnt_nxt     = r_word_cnt;
    w_table_length_nxt = r_table_length;
    w_status_nxt       = r_status;
    w_length_wstb_nxt  = 1'b0;
    w_done_nxt         = 1'b0;
    w_table_wstb_nxt   = w_accept;
    w_table_data_nxt   = w_accept ? data_i : r_table_data;

    unique case (r_state)
      S_IDLE: begin
        // busy_o is still high in the cycle after DONE, so requests are gated on it.
        if (load_req_i && !r_busy) begin
          if (w_len_bad) begin
            w_status_nxt = ST_BAD_LEN;
          end else begin
            w_len_nxt    = load_len_i;
            w_status_nxt = ST_OK;
            w_state_nxt  = S_WAIT_INACTIVE;
          end
        end
      end
      S_WAIT_INACTIVE: begin
        if (!seq_active_i) begin
          w_state_nxt = S_START;
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_status_nxt = ST_TIMEOUT;
        end
      end
      S_START: begin
        w_word_cnt_nxt = '0;
        w_state_nxt    = S_DATA;
      end
      S_DATA: begin
        if (w_accept) begin
          w_word_cnt_nxt = r_word_cnt + LEN_W'(1);
          if (w_word_cnt_nxt == r_len) begin
            w_state_nxt = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        w_table_length_nxt = r_len;
        w_length_wstb_nxt  = 1'b1;
        w_state_nxt        = S_DONE;
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort beats everything except a word strobe that is already committed.
    if (abort_i && (r_state != S_IDLE)) begin
      w_state_nxt        = S_IDLE;
      w_status_nxt       = ST_ABORTED;
      w_length_wstb_nxt  = 1'b0;
      w_done_nxt         = 1'b0;
      w_table_length_nxt = r_table_length;
    end

    w_table_start_nxt = (w_state_nxt == S_START);
    w_ready_nxt       = (w_state_nxt == S_DATA) && (w_word_cnt_nxt < w_len_nxt);
    w_busy_nxt        = (w_state_nxt != S_IDLE) || w_done_nxt;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_word_cnt     <= '0;
      r_table_length <= '0;
      r_table_data   <= '0;
      r_status       <= ST_OK;
      r_ready        <= 1'b0;
      r_table_start  <= 1'b0;
      r_table_wstb   <= 1'b0;
      r_length_wstb  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_len          <= w_len_nxt;
      r_word_cnt     <= w_word_cnt_nxt;
      r_table_length <= w_table_length_nxt;
      r_table_data   <= w_table_data_nxt;
      r_status       <= w_status_nxt;
      r_ready        <= w_ready_nxt;
      r_table_start  <= w_table_start_nxt;
      r_table_wstb   <= w_table_wstb_nxt;
      r_length_wstb  <= w_length_wstb_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
    end
  end

  assign data_ready_o        = r_ready;
  assign table_start_o       = r_table_start;
  assign table_data_o        = r_table_data;
  assign table_wstb_o        = r_table_wstb;
  assign table_length_o      = r_table_length;
  assign table_length_wstb_o = r_length_wstb;
  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign status_o            = r_status;

endmodule

// File: tb/tb_panda_seq_table_ctrl.sv
// Bench for panda_seq_table_ctrl: open-loop stimulus, expected output timeline
// derived per load from the event schedule (start, accepts, commit, done).
module tb_panda_seq_table_ctrl;

  localparam int FRAME_WORDS = 4;
  localparam int MAX_WORDS   = 4096;
  localparam int TMAX        = 4400;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        load_req_i;
  logic [15:0] load_len_i;
  logic        abort_i;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic        seq_active_i;
  logic        table_start_o;
  logic [31:0] table_data_o;
  logic        table_wstb_o;
  logic [15:0] table_length_o;
  logic        table_length_wstb_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  status_o;

  panda_seq_table_ctrl #(
    .FRAME_WORDS(FRAME_WORDS),
    .MAX_WORDS  (MAX_WORDS)
  ) dut (
    .clk_i              (clk_i),
    .reset_ni           (reset_ni),
    .load_req_i         (load_req_i),
    .load_len_i         (load_len_i),
    .abort_i            (abort_i),
    .data_i             (data_i),
    .data_valid_i       (data_valid_i),
    .data_ready_o       (data_ready_o),
    .seq_active_i       (seq_active_i),
    .table_start_o      (table_start_o),
    .table_data_o       (table_data_o),
    .table_wstb_o       (table_wstb_o),
    .table_length_o     (table_length_o),
    .table_length_wstb_o(table_length_wstb_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .status_o           (status_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Persistent output values that hold across loads.
  logic [31:0] exp_data;
  logic [31:0] exp_length;
  logic [1:0]  exp_status;

  bit          v_arr [TMAX];
  logic [31:0] d_arr [TMAX];
  bit          a_arr [TMAX];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ":ready"},    32'(data_ready_o),        32'd0);
    check_eq({tag, ":start"},    32'(table_start_o),       32'd0);
    check_eq({tag, ":data"},     table_data_o,             32'd0);
    check_eq({tag, ":wstb"},     32'(table_wstb_o),        32'd0);
    check_eq({tag, ":length"},   32'(table_length_o),      32'd0);
    check_eq({tag, ":len_wstb"}, 32'(table_length_wstb_o), 32'd0);
    check_eq({tag, ":busy"},     32'(busy_o),              32'd0);
    check_eq({tag, ":done"},     32'(done_o),              32'd0);
    check_eq({tag, ":status"},   32'(status_o),            32'd0);
  endtask

  // One load request at relative cycle 0. sb_last: last cycle with seq_active high
  // (-1 = never). vmode: valid probability in percent, or >100 for alternate cycles.
  // t_ab: cycle abort_i is pulsed (-1 = none). extra: a second request while busy.
  task automatic run_load(input int len, input int sb_last, input int vmode,
                          input int t_ab, input bit extra, input bit ramp);
    bit          good, ab_eff, len_wr;
    int          tw, ts, n_last, cnt, end_busy, t_end, t_r2, exp_wstb_n, got_wstb_n;
    logic [15:0] len2;
    good = (len > 0) && (len <= MAX_WORDS) && (len % FRAME_WORDS == 0);
    tw   = (sb_last + 1 > 1) ? sb_last + 1 : 1;
    ts   = tw + 1;
    for (int t = 0; t < TMAX; t++) begin
      if (vmode > 100) v_arr[t] = ((t % 2) == 1);
      else             v_arr[t] = (int'($urandom_range(99)) < vmode) || (t > TMAX / 2);
      d_arr[t] = ramp ? 32'(t - ts) : $urandom();
      a_arr[t] = 1'b0;
    end
    n_last = ts;
    cnt    = 0;
    if (good) begin
      for (int t = ts + 1; t < TMAX && cnt < len; t++) begin
        if (v_arr[t]) begin
          a_arr[t] = 1'b1;
          cnt++;
          n_last = t;
        end
      end
      if (cnt < len) begin
        $display("FAIL model_span words=%0d len=%0d", cnt, len);
        $fatal(1);
      end
    end
    ab_eff = good && (t_ab >= 1) && (t_ab <= n_last + 2);
    if (ab_eff) for (int t = t_ab + 1; t < TMAX; t++) a_arr[t] = 1'b0;
    exp_wstb_n = 0;
    for (int t = 0; t < TMAX; t++) if (a_arr[t]) exp_wstb_n++;
    end_busy = !good ? 0 : (ab_eff ? t_ab : n_last + 3);
    t_end    = good ? end_busy + 3 : 3;
    t_r2     = (extra && good) ? int'($urandom_range(end_busy, 1)) : -1;
    len2     = 16'($urandom_range(40));
    got_wstb_n = 0;

    for (int t = 0; t <= t_end; t++) begin
      @(posedge clk_i); #1;
      load_req_i   = (t == 0) || (t == t_r2);
      load_len_i   = (t == t_r2) ? len2 : 16'(len);
      abort_i      = (t == t_ab);
      seq_active_i = (t <= sb_last);
      data_valid_i = v_arr[t];
      data_i       = d_arr[t];
      @(negedge clk_i);
      if (t == 1) exp_status = good ? 2'd0 : 2'd1;
      if (ab_eff && t == t_ab + 1) exp_status = 2'd3;
      if (t >= 1 && a_arr[t-1]) exp_data = d_arr[t-1];
      len_wr = good && (t == n_last + 2) && (!ab_eff || t_ab >= n_last + 2);
      if (len_wr) exp_length = 32'(len);
      check_eq($sformatf("start@%0d", t), 32'(table_start_o),
               32'(good && t == ts && (!ab_eff || t_ab >= ts)));
      check_eq($sformatf("ready@%0d", t), 32'(data_ready_o),
               32'(good && t >= ts + 1 && t <= n_last && (!ab_eff || t <= t_ab)));
      check_eq($sformatf("wstb@%0d", t), 32'(table_wstb_o), 32'(t >= 1 && a_arr[t-1]));
      check_eq($sformatf("data@%0d", t), table_data_o, exp_data);
      check_eq($sformatf("len_wstb@%0d", t), 32'(table_length_wstb_o), 32'(len_wr));
      check_eq($sformatf("length@%0d", t), 32'(table_length_o), exp_length);
      check_eq($sformatf("done@%0d", t), 32'(done_o), 32'(good && !ab_eff && t == n_last + 3));
      check_eq($sformatf("busy@%0d", t), 32'(busy_o), 32'(good && t >= 1 && t <= end_busy));
      check_eq($sformatf("status@%0d", t), 32'(status_o), 32'(exp_status));
      if (table_wstb_o) got_wstb_n++;
    end
    check_eq($sformatf("wstb_count len=%0d", len), 32'(got_wstb_n), 32'(exp_wstb_n));
  endtask

  initial begin
    reset_ni     = 1'b0;
    load_req_i   = 1'b0;
    load_len_i   = '0;
    abort_i      = 1'b0;
    data_i       = '0;
    data_valid_i = 1'b0;
    seq_active_i = 1'b0;
    exp_data     = '0;
    exp_length   = '0;
    exp_status   = 2'd0;
    repeat (3) @(posedge clk_i);
    #1 check_quiet("reset");
    @(negedge clk_i) reset_ni = 1'b1;

    run_load(8, -1, 100, -1, 1'b0, 1'b1);   // normal load, words 1..8
    run_load(0, -1, 100, -1, 1'b0, 1'b0);   // bad lengths
    run_load(6, -1, 100, 1, 1'b0, 1'b0);    // abort in IDLE ignored
    run_load(4100, -1, 100, -1, 1'b0, 1'b0);
    run_load(8, 50, 100, -1, 1'b0, 1'b0);   // sequencer busy for 51 cycles
    run_load(4, -1, 101, -1, 1'b0, 1'b0);   // throttled stream
    run_load(8, -1, 100, 5, 1'b0, 1'b1);    // abort with 3rd word accept
    run_load(8, -1, 100, 0, 1'b0, 1'b0);    // abort with the request: ignored
    run_load(8, 3, 100, 4, 1'b0, 1'b0);     // abort as sequencer goes idle: no start
    run_load(8, -1, 70, -1, 1'b1, 1'b0);    // request while busy ignored
    run_load(4096, -1, 100, -1, 1'b0, 1'b0); // largest legal length

    // Reset mid-DATA: outputs clear at once, no strobes while held.
    @(posedge clk_i); #1;
    load_req_i = 1'b1; load_len_i = 16'd8; seq_active_i = 1'b0;
    data_valid_i = 1'b1; data_i = 32'hA5A5_0001; abort_i = 1'b0;
    @(posedge clk_i); #1;
    load_req_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3 reset_ni = 1'b0;
    #1 check_quiet("async_rst");
    @(posedge clk_i); #1 check_quiet("rst_held");
    data_valid_i = 1'b0;
    exp_data   = '0;
    exp_length = '0;
    exp_status = 2'd0;
    @(negedge clk_i) reset_ni = 1'b1;
    run_load(4, -1, 100, -1, 1'b1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int len, sb, vm, tab;
      if ($urandom_range(4) == 0) len = int'($urandom_range(40));
      else                        len = 4 * int'($urandom_range(8, 1));
      sb  = int'($urandom_range(12)) - 1;
      vm  = int'($urandom_range(100, 30));
      tab = ($urandom_range(3) == 0) ? int'($urandom_range(60)) : -1;
      run_load(len, sb, vm, tab, 1'($urandom_range(1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim_time=%0t limit=5ms", $time);
    $fatal(1);
  end

endmodule

// File: doc/panda_seq_table_ctrl.md
# panda_seq_table_ctrl

Table-load controller for `panda_sequencer`. It accepts a load request plus a word stream, waits until the sequencer is inactive, then drives the sequencer's table write port: `TABLE_START`, `TABLE_DATA`/`TABLE_WSTB` and `TABLE_LENGTH`/`TABLE_LENGTH_WSTB`. It sits between the register/DMA front end and the sequencer, and is the only master of the sequencer table port.

## Interface
Parameters:
- `FRAME_WORDS`, 4, words per sequencer frame; load length must be a multiple of this.
- `MAX_WORDS`, 4096, largest accepted load length in words.
- `TIMEOUT`, 125000, maximum cycles spent in WAIT_INACTIVE (only with `SEQ_TBL_TIMEOUT_EN`).

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: system clock.
- `reset_ni` in 1: asynchronous active-low reset.
- `load_req_i` in 1: single-cycle load request.
- `load_len_i` in 16: number of table words, sampled with `load_req_i`.
- `abort_i` in 1: cancels a load in progress.
- `data_i` in 32: table word stream.
- `data_valid_i` in 1: stream valid.
- `data_ready_o` out 1: stream ready.
- `seq_active_i` in 1: sequencer `active_o`.
- `table_start_o` out 1: to `TABLE_START`.
- `table_data_o` out 32: to `TABLE_DATA`.
- `table_wstb_o` out 1: to `TABLE_WSTB`.
- `table_length_o` out 16: to `TABLE_LENGTH`.
- `table_length_wstb_o` out 1: to `TABLE_LENGTH_WSTB`.
- `busy_o` out 1: load in progress.
- `done_o` out 1: single-cycle load-complete pulse.
- `status_o` out 2: 0 ok, 1 bad length, 2 timeout, 3 aborted.

## Operation
- States: IDLE, WAIT_INACTIVE, START, DATA, COMMIT, DONE.
- **IDLE:**
  - `load_req_i` with `load_len_i` = 0, greater than `MAX_WORDS`, or `load_len_i % FRAME_WORDS` ≠ 0 → `status_o`=1, stay IDLE.
  - Any other `load_req_i` → latch length, clear `status_o` to 0, go to WAIT_INACTIVE.
- **WAIT_INACTIVE:** leave for START in the first cycle `seq_active_i`=0.
- **START:** `table_start_o` high for exactly one cycle, word counter cleared → DATA.
- **DATA:**
  - `data_ready_o` = 1 while the accepted-word count is below the latched length.
  - Each `data_valid_i && data_ready_o` cycle accepts one word and increments the 16-bit counter.
  - Accepting the last word → COMMIT.
- **COMMIT:** `table_length_o` = latched length, `table_length_wstb_o` pulses for one cycle → DONE.
- **DONE:** `done_o` for one cycle → IDLE.
- **Abort:** `abort_i` in any non-IDLE state → IDLE next cycle with `status_o`=3.
  - No further `table_wstb_o` and no length write. The sequencer table is left in its post-START (empty) state.
  - `abort_i` in IDLE is ignored.
- **Simultaneous events:**
  - `load_req_i` while `busy_o`=1 is ignored; `status_o` is unchanged.
  - `abort_i` in the cycle the last word is accepted: abort wins. That word's `table_wstb_o` still issues (it is already registered), but COMMIT is skipped.
- `status_o` holds its value until the next accepted `load_req_i`.

## Timing
- Reset values: all outputs 0, `table_data_o`=0, `table_length_o`=0, state IDLE.
- Reset asserted mid-load returns to IDLE immediately; no further strobes are issued.
- `busy_o` is high from the cycle after an accepted `load_req_i` through the DONE cycle inclusive, and also after an abort until the return to IDLE.
- **Start latency:** if `seq_active_i`=0 on request, `table_start_o` is high at request+2 (WAIT_INACTIVE then START).
- **Word path:**
  - `data_ready_o` is decoded from registered state/counter only, with no combinational path from `data_valid_i`.
  - `table_data_o`/`table_wstb_o` are registered and appear 1 cycle after acceptance. `table_data_o` holds its last value between strobes.
- **Completion:** with the last word accepted at cycle N:
  - `table_wstb_o` at N+1 (COMMIT state).
  - `table_length_wstb_o` at N+2.
  - `done_o` at N+3.
  - `busy_o` low at N+4.
- **Back-to-back words:** full throughput, one word per cycle.

## Configuration
- `SEQ_TBL_TIMEOUT_EN` defined:
  - A 32-bit counter runs in WAIT_INACTIVE.
  - Reaching `TIMEOUT` cycles with `seq_active_i` still high → IDLE, `status_o`=2, no `table_start_o`.
- Not defined: WAIT_INACTIVE waits indefinitely (exit only via `seq_active_i`=0, `abort_i` or reset), and `TIMEOUT` is unused.

## Test plan
- **Normal load:** `seq_active_i`=0, load_len=8, 8 back-to-back words 0x1..0x8 →
  - `table_start_o` at req+2.
  - 8 `table_wstb_o` with data 0x1..0x8.
  - `table_length_o`=8 with `table_length_wstb_o` 1 cycle after the last wstb.
  - `done_o` next cycle; `status_o`=0.
- **Bad lengths:** load_len=0, 6 and 4100 → `status_o`=1 each time; no strobes; `busy_o` stays 0.
- **Sequencer busy:** `seq_active_i`=1 for 50 cycles, then 0 → no `table_start_o` until the cycle after `seq_active_i` falls.
  - With `SEQ_TBL_TIMEOUT_EN` and `TIMEOUT`=20: `status_o`=2 at req+22 and no start.
- **Throttled stream:** `data_valid_i` toggling every other cycle, load_len=4 → exactly 4 wstb, each 1 cycle after its accept; length write 4.
- **Abort:** `abort_i` after 3 of 8 words accepted → exactly 3 wstb, no `table_length_wstb_o`, `status_o`=3, `done_o` never pulses.
- **Reset and re-request:** `reset_ni` pulled low mid-DATA → all outputs 0 immediately; after release, a new 4-word load completes normally. A second `load_req_i` issued while busy is ignored.
